fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage with PC generation and an IF/ID pipeline register. It drives the byte address into the combinational instruction memory and receives the 32-bit instruction word in the same cycle. It registers the word with its PC for the decode stage. It handles sequential advance, stall, and branch/jump redirect with bubble insertion.

## Interface
Parameters:
- ADDRESS_WIDTH, 16, width of the byte address / PC
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset (must be a multiple of 4)
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hazard stall from decode; hold PC and IF/ID
- redirect  input  1  branch-taken/jump from execute
- redirect_target  input  ADDRESS_WIDTH  new fetch byte address
- PC  output  ADDRESS_WIDTH  fetch address to instruction memory (registered)
- instr  input  DATA_WIDTH  word returned by instruction memory for PC (combinational)
- id_valid  output  1  IF/ID holds a real instruction
- id_instr  output  DATA_WIDTH  registered instruction
- id_pc  output  ADDRESS_WIDTH  PC of id_instr
- id_pc_plus4  output  ADDRESS_WIDTH  id_pc + 4, mod 2^ADDRESS_WIDTH
- fetch_count  output  32  number of instructions delivered to IF/ID

## Operation
- State: PC register, IF/ID register {id_valid, id_instr, id_pc, id_pc_plus4}, and fetch_count.
- Reset (async, immediate on rst=1):
  - PC=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, fetch_count=0.
  - All outputs hold these values while rst is high.
- Each rising edge with rst=0 applies the first matching rule:
  1. redirect=1:
     - PC <= {redirect_target[ADDRESS_WIDTH-1:2], 2'b00}. The low two bits are forced to zero.
     - IF/ID <= bubble: id_valid=0, id_instr=NOP_INSTR, id_pc and id_pc_plus4 hold their previous values.
     - fetch_count unchanged.
  2. stall=1: PC, IF/ID and fetch_count all hold.
  3. Otherwise:
     - IF/ID <= {1, instr, PC, PC+4}.
     - PC <= PC+4.
     - fetch_count <= fetch_count+1.
- redirect has priority over stall. The instruction in IF/ID is on the wrong path and is squashed even when decode requested a stall.
- Arithmetic:
  - PC+4 wraps modulo 2^ADDRESS_WIDTH; 0xFFFC advances to 0x0000 with no flag.
  - fetch_count wraps modulo 2^32.
- PC is always 4-byte aligned: RESET_PC is aligned and the low bits of every redirect are cleared.

## Timing
- The PC output comes directly from a register, with no combinational path from any input.
- instr is sampled in the same cycle PC is presented. Instruction memory read latency is zero.
- Fetch-to-decode latency is 1 cycle. The word at address A appears on id_instr one edge after PC=A, provided that edge is not a stall or redirect.
- Redirect penalty:
  - At least one bubble: the edge that accepts redirect writes a bubble.
  - The target's word reaches IF/ID on the next non-stalled edge.
- Stall has no effect on an edge where redirect is also high.
- Reset asserted mid-stream clears state asynchronously, without waiting for a clock edge.
- After rst deasserts, the first edge fetches RESET_PC.

## Test plan
- Reset then free-run, with memory holding 0x11111111@0, 0x22222222@4, 0x33333333@8:
  - During reset, PC=0 and id_valid=0.
  - Edge 1: id_instr=0x11111111, id_pc=0, id_pc_plus4=4.
  - Edge 3: id_instr=0x33333333, fetch_count=3.
- Stall for 2 cycles with PC=8 and id_pc=4: PC stays 8 and id_pc stays 4 for both edges. After stall drops, id_pc=8 and fetch_count increments once.
- redirect=1, redirect_target=0x0042:
  - Next edge: PC=0x0040, id_valid=0, id_instr=0x00000013.
  - Following edge: id_pc=0x0040 and id_valid=1.
- stall=1 and redirect=1 on the same edge, target 0x0100: PC=0x0100 and IF/ID becomes a bubble, so redirect wins over stall.
- Wrap-around: redirect to 0xFFFC, then run 2 edges. id_pc=0xFFFC with id_pc_plus4=0x0000, then id_pc=0x0000.
- Async reset pulse between edges while PC=0x20:
  - PC=RESET_PC, id_valid=0 and fetch_count=0 before the next clock edge.
  - Normal fetch from RESET_PC resumes after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, same-cycle instruction memory read, IF/ID register.
// Redirect overrides stall and loads a bubble; stall freezes everything.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR     = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic [ADDRESS_WIDTH-1:0] PC,
    input  logic [DATA_WIDTH-1:0]    instr,
    output logic                     id_valid,
    output logic [DATA_WIDTH-1:0]    id_instr,
    output logic [ADDRESS_WIDTH-1:0] id_pc,
    output logic [ADDRESS_WIDTH-1:0] id_pc_plus4,
    output logic [31:0]              fetch_count
);

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     vld_q, vld_d;
    logic [DATA_WIDTH-1:0]    ins_q, ins_d;
    logic [ADDRESS_WIDTH-1:0] ipc_q, ipc_d;
    logic [ADDRESS_WIDTH-1:0] p4_q, p4_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;

    // Natural-width add drops the carry, giving the mod 2^ADDRESS_WIDTH wrap.
    assign pc_plus4 = pc_q + ADDRESS_WIDTH'(4);

    always_comb begin
        pc_d  = pc_q;
        vld_d = vld_q;
        ins_d = ins_q;
        ipc_d = ipc_q;
        p4_d  = p4_q;
        cnt_d = cnt_q;
        if (redirect) begin
            // Squash the wrong-path word even if decode is stalling; id_pc/id_pc_plus4 keep old values.
            pc_d  = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
            vld_d = 1'b0;
            ins_d = NOP_INSTR;
        end else if (!stall) begin
            pc_d  = pc_plus4;
            vld_d = 1'b1;
            ins_d = instr;
            ipc_d = pc_q;
            p4_d  = pc_plus4;
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            vld_q <= 1'b0;
            ins_q <= NOP_INSTR;
            ipc_q <= '0;
            p4_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            vld_q <= vld_d;
            ins_q <= ins_d;
            ipc_q <= ipc_d;
            p4_q  <= p4_d;
            cnt_q <= cnt_d;
        end
    end

    assign PC          = pc_q;
    assign id_valid    = vld_q;
    assign id_instr    = ins_q;
    assign id_pc       = ipc_q;
    assign id_pc_plus4 = p4_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver pushes the expected post-edge state from a
// behavioural model, a monitor pops and compares after every rising edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [15:0] redirect_target, PC, id_pc, id_pc_plus4;
    logic [31:0] instr, id_instr, fetch_count;
    logic        id_valid;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] pc;
        logic        v;
        logic [31:0] ins;
        logic [15:0] ipc;
        logic [15:0] p4;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t m;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [15:0] a);
        case (a)
            16'h0000: return 32'h11111111;
            16'h0004: return 32'h22222222;
            16'h0008: return 32'h33333333;
            default:  return {~a, a};
        endcase
    endfunction

    assign instr = mem(PC);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .PC(PC), .instr(instr),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .fetch_count(fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m.pc = 16'h0; m.v = 1'b0; m.ins = NOP; m.ipc = 16'h0; m.p4 = 16'h0; m.cnt = 32'd0;
    endtask

    // Drive inputs for the coming edge and queue the state the spec says that edge produces.
    task automatic drive(input logic s, input logic r, input logic [15:0] t);
        stall = s; redirect = r; redirect_target = t;
        if (r) begin
            m.pc  = t & 16'hFFFC;
            m.v   = 1'b0;
            m.ins = NOP;
        end else if (!s) begin
            m.v   = 1'b1;
            m.ins = mem(m.pc);
            m.ipc = m.pc;
            m.p4  = m.pc + 16'd4;
            m.pc  = m.pc + 16'd4;
            m.cnt = m.cnt + 32'd1;
        end
        q.push_back(m);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        chk("async_rst_pc", {16'h0, PC}, 32'h0);
        chk("async_rst_valid", {31'h0, id_valid}, 32'h0);
        chk("async_rst_count", fetch_count, 32'h0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", {16'h0, PC}, {16'h0, e.pc});
                chk("id_valid", {31'h0, id_valid}, {31'h0, e.v});
                chk("id_instr", id_instr, e.ins);
                chk("id_pc", {16'h0, id_pc}, {16'h0, e.ipc});
                chk("id_pc_plus4", {16'h0, id_pc_plus4}, {16'h0, e.p4});
                chk("fetch_count", fetch_count, e.cnt);
            end
        end
    end

    // Driver
    initial begin
        int r;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 16'h0;
        model_reset();
        #2;
        chk("rst_pc", {16'h0, PC}, 32'h0);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, NOP);
        chk("rst_id_pc", {16'h0, id_pc}, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        @(negedge clk); rst = 1'b0; drive(0, 0, 16'h0);
        @(negedge clk); drive(0, 0, 16'h0);
        @(negedge clk); drive(1, 0, 16'h0);
        @(negedge clk); drive(1, 0, 16'h0);
        @(negedge clk); drive(0, 0, 16'h0);
        @(negedge clk); drive(0, 0, 16'h0);
        @(negedge clk); drive(0, 1, 16'h0042);
        @(negedge clk); drive(0, 0, 16'h0);
        @(negedge clk); drive(1, 1, 16'h0100);
        @(negedge clk); drive(0, 0, 16'h0);
        @(negedge clk); drive(0, 1, 16'hFFFC);
        @(negedge clk); drive(0, 0, 16'h0);
        @(negedge clk); drive(0, 0, 16'h0);
        @(negedge clk); drive(0, 0, 16'h0);
        @(negedge clk); drive(0, 1, 16'h001F);
        @(negedge clk); drive(0, 0, 16'h0);
        @(negedge clk); reset_pulse(); drive(0, 0, 16'h0);
        @(negedge clk); drive(0, 0, 16'h0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            if (r < 2) reset_pulse();
            drive(($urandom_range(0, 3) == 0), (r >= 90), 16'($urandom));
        end
        @(negedge clk); drive(0, 0, 16'h0);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
